// File: rtl/alarm_msg_uart_tx_if.sv
// Handshake bundle between the alarm controller side and the alert UART.
interface alarm_msg_uart_tx_if;
  logic mensaje;
  logic gases;
  logic movimiento;
  logic tx;
  logic busy;
  logic done;

  modport master (output mensaje, gases, movimiento, input tx, busy, done);
  modport slave  (input mensaje, gases, movimiento, output tx, busy, done);
endinterface

// File: rtl/alarm_msg_uart_tx.sv
// Sends the 10-byte "ALARMA <cause>\r\n" alert over 8N1 UART on each
// rising edge of mensaje; the cause is latched at trigger time.
module alarm_msg_uart_tx #(
  parameter int CLK_HZ       = 25000000,
  parameter int BAUD         = 9600,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
  input logic                clk,
  input logic                rst,
  alarm_msg_uart_tx_if.slave bus
);

  localparam int             CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [7:0]     CAUSE_G = 8'h47;
  localparam logic [7:0]     CAUSE_M = 8'h4D;
  localparam logic [7:0]     CAUSE_X = 8'h58;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  // bit 0 = mensaje, bit 1 = gases, bit 2 = movimiento
  logic [2:0]    meta_q, meta_d;
  logic [2:0]    sync_q, sync_d;
  logic          prev_q, prev_d;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [3:0]    byte_q, byte_d;
  logic [7:0]    sel_q, sel_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          rise;
  logic          accept;
  logic          bit_end;
  logic [7:0]    cur_byte;

  function automatic logic [7:0] msg_byte(input logic [3:0] idx, input logic [7:0] cause);
    case (idx)
      4'd0:    return 8'h41;
      4'd1:    return 8'h4C;
      4'd2:    return 8'h41;
      4'd3:    return 8'h52;
      4'd4:    return 8'h4D;
      4'd5:    return 8'h41;
      4'd6:    return 8'h20;
      4'd7:    return cause;
      4'd8:    return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  // Edge is only honoured in a true IDLE cycle, not the one carrying done.
  assign rise    = sync_q[0] & ~prev_q;
  assign accept  = (state_q == S_IDLE) & ~done_q & rise;
  assign bit_end = (cnt_q == CNT_MAX);

  // Two-flop synchronizers plus the edge-detect history flop.
  always_comb begin
    meta_d = {bus.movimiento, bus.gases, bus.mensaje};
    sync_d = meta_q;
    prev_d = sync_q[0];
  end

  // Next-state logic: framing walks START -> 8x DATA -> STOP per byte.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    sel_d   = sel_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_START;
          cnt_d   = '0;
          bit_d   = '0;
          byte_d  = '0;
          sel_d   = sync_q[1] ? CAUSE_G : (sync_q[2] ? CAUSE_M : CAUSE_X);
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (byte_q < 4'd9) begin
            byte_d  = byte_q + 4'd1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered tx lines up
  // with the state it belongs to and never glitches.
  always_comb begin
    cur_byte = msg_byte(byte_d, sel_d);
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_q == S_STOP) && (state_d == S_IDLE);
    unique case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = cur_byte[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  // State register; reset abandons any frame and forces the line idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q  <= '0;
      sync_q  <= '0;
      prev_q  <= 1'b0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      sel_q   <= CAUSE_X;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      sel_q   <= sel_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_alarm_msg_uart_tx.sv
// Bench for alarm_msg_uart_tx: queue-based waveform model checked every
// cycle, a UART decoder for literal byte checks, directed + random stimulus.
module tb_alarm_msg_uart_tx;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst = 1'b0;
  logic mensaje = 1'b0, gases = 1'b0, movimiento = 1'b0;
  logic tx, busy, done;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int cyc      = 0;

  alarm_msg_uart_tx_if bus ();
  assign bus.mensaje    = mensaje;
  assign bus.gases      = gases;
  assign bus.movimiento = movimiento;
  assign tx   = bus.tx;
  assign busy = bus.busy;
  assign done = bus.done;

  alarm_msg_uart_tx #(.CLK_HZ(40), .BAUD(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = clk_en ? ~clk : clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // ---------------- behavioural model ----------------
  // On acceptance the whole expected waveform {tx,busy,done} of the message
  // is queued up front; each clock pops one entry.
  logic       e_tx = 1'b1, e_busy = 1'b0, e_done = 1'b0;
  logic [2:0] ms = '0, gs = '0, vs = '0;  // [0] sync1, [1] sync2, [2] prev
  logic [2:0] wave_q[$];

  task automatic build(input logic [7:0] cause);
    logic [7:0] m [10];
    logic       b;
    m = '{8'h41, 8'h4C, 8'h41, 8'h52, 8'h4D, 8'h41, 8'h20, 8'h00, 8'h0D, 8'h0A};
    m[7] = cause;
    for (int i = 0; i < 10; i++)
      for (int k = 0; k < 10; k++) begin
        b = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : m[i][k-1];
        repeat (CPB) wave_q.push_back({b, 1'b1, 1'b0});
      end
    wave_q.push_back(3'b101);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ms = '0; gs = '0; vs = '0;
      wave_q.delete();
      e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0;
    end else begin
      if (ms[1] && !ms[2] && wave_q.size() == 0 && !e_done)
        build(gs[1] ? 8'h47 : (vs[1] ? 8'h4D : 8'h58));
      ms = {ms[1], ms[0], mensaje};
      gs = {gs[1], gs[0], gases};
      vs = {vs[1], vs[0], movimiento};
      if (wave_q.size() != 0) {e_tx, e_busy, e_done} = wave_q.pop_front();
      else {e_tx, e_busy, e_done} = 3'b100;
    end
  end

  always @(negedge clk) chk("cycle_tx_busy_done", {tx, busy, done}, {e_tx, e_busy, e_done});

  // ---------------- UART decoder / counters ----------------
  logic [7:0] rx_q[$];
  logic [7:0] sh = '0;
  int busy_cnt = 0, done_cnt = 0, fall_cyc = -1, frm_err = 0, rx_t = 0;
  bit in_frm = 1'b0;

  always @(negedge clk) begin
    if (rst) in_frm = 1'b0;
    else begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (!in_frm) begin
        if (tx == 1'b0) begin
          in_frm = 1'b1; rx_t = 0;
          if (fall_cyc < 0) fall_cyc = cyc;
        end
      end else rx_t++;
      if (in_frm) begin
        if (rx_t == CPB / 2 && tx !== 1'b0) frm_err++;
        if (rx_t >= CPB + CPB / 2 && rx_t <= 8 * CPB + CPB / 2 && (rx_t - CPB / 2) % CPB == 0)
          sh[(rx_t - CPB / 2) / CPB - 1] = tx;
        if (rx_t == 9 * CPB + CPB / 2) begin
          if (tx !== 1'b1) frm_err++;
          rx_q.push_back(sh);
        end
        if (rx_t == 10 * CPB - 1) in_frm = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int first_edge = 0;

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clr();
    rx_q.delete(); busy_cnt = 0; done_cnt = 0; fall_cyc = -1; frm_err = 0;
  endtask

  task automatic trigger(input logic g, input logic m, input int len);
    gases = g; movimiento = m;
    nclk(3);
    first_edge = cyc + 1;
    mensaje = 1'b1;
    nclk(len);
    mensaje = 1'b0;
  endtask

  task automatic wait_done(input int n, input int lim);
    int t = 0;
    while (done_cnt < n && t < lim) begin nclk(1); t++; end
    chk("done_within_bound", done_cnt, n);
  endtask

  task automatic wait_bytes(input int n, input int lim);
    int t = 0;
    while (rx_q.size() < n && t < lim) begin nclk(1); t++; end
    chk("bytes_within_bound", rx_q.size(), n);
  endtask

  task automatic run_msg(input logic g, input logic m, input logic [7:0] cause);
    clr();
    trigger(g, m, 3);
    wait_done(1, 600);
    nclk(10);
    chk("msg_nbytes", rx_q.size(), 10);
    if (rx_q.size() == 10) begin
      chk("msg_byte0", rx_q[0], 8'h41);
      chk("msg_cause", rx_q[7], cause);
    end
    chk("msg_busy_cycles", busy_cnt, 400);
    chk("msg_done_pulses", done_cnt, 1);
    chk("msg_frame_err", frm_err, 0);
    chk("msg_tx_latency", fall_cyc - first_edge, 2);
  endtask

  logic [7:0] exp_gas [10];

  initial begin
    exp_gas = '{8'h41, 8'h4C, 8'h41, 8'h52, 8'h4D, 8'h41, 8'h20, 8'h47, 8'h0D, 8'h0A};

    // reset with no clock running
    #1 rst = 1'b1;
    #4;
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    clk_en = 1'b1;
    nclk(2);
    rst = 1'b0;
    clr();
    nclk(50);
    chk("idle_tx", tx, 1'b1);
    chk("idle_no_frames", rx_q.size(), 0);

    // gas message, full literal byte check
    run_msg(1'b1, 1'b0, 8'h47);
    if (rx_q.size() == 10)
      for (int i = 0; i < 10; i++) chk($sformatf("gas_byte%0d", i), rx_q[i], exp_gas[i]);

    // cause selection
    run_msg(1'b0, 1'b1, 8'h4D);
    run_msg(1'b0, 1'b0, 8'h58);
    run_msg(1'b1, 1'b1, 8'h47);

    // drop and latch: edge + gas change during byte 3
    clr();
    trigger(1'b0, 1'b0, 2);
    wait_bytes(3, 300);
    nclk(6);
    gases = 1'b1; mensaje = 1'b1;
    nclk(3);
    mensaje = 1'b0;
    wait_done(1, 600);
    nclk(500);
    chk("drop_nbytes", rx_q.size(), 10);
    if (rx_q.size() == 10) chk("drop_cause", rx_q[7], 8'h58);
    chk("drop_done_pulses", done_cnt, 1);

    // reset mid-message
    clr();
    trigger(1'b1, 1'b0, 2);
    wait_bytes(4, 300);
    nclk(5);
    rst = 1'b1;
    #1;
    chk("midrst_tx", tx, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    nclk(3);
    rst = 1'b0;
    nclk(30);
    chk("midrst_no_done", done_cnt, 0);
    run_msg(1'b1, 1'b0, 8'h47);

    // held level: one message, then a second after re-raising
    clr();
    gases = 1'b0; movimiento = 1'b1;
    nclk(3);
    mensaje = 1'b1;
    nclk(1000);
    chk("held_done_pulses", done_cnt, 1);
    chk("held_nbytes", rx_q.size(), 10);
    mensaje = 1'b0;
    nclk(5);
    mensaje = 1'b1;
    nclk(3);
    mensaje = 1'b0;
    wait_done(2, 600);
    nclk(10);
    chk("held_second_nbytes", rx_q.size(), 20);

    // earliest retrigger: sampled at the done edge, accepted one idle cycle later
    clr();
    trigger(1'b0, 1'b0, 3);
    begin
      int t = 0;
      while (cyc < first_edge + 401 && t < 600) begin nclk(1); t++; end
    end
    mensaje = 1'b1;
    nclk(3);
    mensaje = 1'b0;
    wait_done(2, 700);
    nclk(10);
    chk("retrig_nbytes", rx_q.size(), 20);
    chk("retrig_busy_cycles", busy_cnt, 800);

    // random stimulus against the model
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(39) == 0) mensaje = ~mensaje;
      if ($urandom_range(59) == 0) gases = ~gases;
      if ($urandom_range(59) == 0) movimiento = ~movimiento;
      if ($urandom_range(1999) == 0) begin
        rst = 1'b1; nclk(2); rst = 1'b0;
      end
      nclk(1);
    end
    mensaje = 1'b0; gases = 1'b0; movimiento = 1'b0;
    nclk(500);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
